// File: rtl/muldiv_seq_if.sv
// Request/response handshake bundle between a client and muldiv_seq.
// The master drives requests and accepts responses; the slave is the sequencer.
interface muldiv_seq_if #(
    parameter int SIZE_A = 128,
    parameter int SIZE_B = 64
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_op;
    logic [SIZE_A-1:0]        req_a;
    logic [SIZE_B-1:0]        req_b;
    logic [3:0]               req_tag;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [SIZE_A+SIZE_B-1:0] rsp_data;
    logic [3:0]               rsp_tag;
    logic                     rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/muldiv_seq.sv
// Request sequencer in front of a multi-cycle multiply/divide core.
// It holds one request at a time, guards divide-by-zero and aborts a core that hangs.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | operands latched, waiting for the core to be free before the start pulse
// WAIT  | core running, timeout counter advancing
// HOLD  | response presented until the consumer takes it
module muldiv_seq #(
    parameter int SIZE_A  = 128,
    parameter int SIZE_B  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    muldiv_seq_if.slave              bus,
    output logic                     core_en,
    output logic                     core_select,
    output logic [SIZE_A-1:0]        core_a,
    output logic [SIZE_B-1:0]        core_b,
    input  logic [SIZE_A+SIZE_B-1:0] core_p,
    input  logic                     core_valid,
    input  logic                     core_busy,
    output logic [15:0]              op_count
);
    localparam int         SIZE_P      = SIZE_A + SIZE_B;
    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [9:0]        wait_cnt;
    logic [3:0]        tag_q;
    logic [SIZE_P-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic accept;
    logic div_zero;
    logic launch;
    logic timeout_hit;

    assign accept      = bus.req_valid && (state == IDLE);
    assign div_zero    = bus.req_op && (bus.req_b == '0);
    // The core is started only when it is neither busy nor flushing a stale result.
    assign launch      = (state == ISSUE) && !core_busy && !core_valid;
    assign timeout_hit = (wait_cnt == TIMEOUT_CNT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = div_zero ? HOLD : ISSUE;
            ISSUE:   if (launch) state_nxt = WAIT;
            WAIT:    if (core_valid || timeout_hit) state_nxt = HOLD;
            HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_en     <= 1'b0;
            core_select <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            tag_q       <= '0;
            wait_cnt    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            op_count    <= '0;
        end else begin
            core_en <= launch;

            if (accept) begin
                core_select <= bus.req_op;
                core_a      <= bus.req_a;
                core_b      <= bus.req_b;
                tag_q       <= bus.req_tag;
                if (div_zero) begin
                    rsp_data_q <= '1;
                    rsp_err_q  <= 1'b1;
                end
            end

            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 10'd1;
            end else begin
                wait_cnt <= '0;
            end

            // A result arriving on the timeout cycle still wins over the abort.
            if (state == WAIT) begin
                if (core_valid) begin
                    rsp_data_q <= core_p;
                    rsp_err_q  <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data_q <= '1;
                    rsp_err_q  <= 1'b1;
                end
            end

            if ((state == HOLD) && bus.rsp_ready && (op_count != 16'hFFFF)) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == HOLD);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: behavioural core model, response scoreboard,
// a vector table and directed sequences for latency, back-pressure, busy core, reset and timeout.
module tb_muldiv_seq;
    localparam int SA = 128;
    localparam int SB = 64;
    localparam int SP = SA + SB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if #(.SIZE_A(SA), .SIZE_B(SB)) bus ();
    muldiv_seq_if #(.SIZE_A(SA), .SIZE_B(SB)) bus2 ();

    logic          core_en, core_select, core_valid, core_busy;
    logic [SA-1:0] core_a;
    logic [SB-1:0] core_b;
    logic [SP-1:0] core_p;
    logic [15:0]   op_count;

    logic          core_en2, core_select2, core_valid2, core_busy2;
    logic [SA-1:0] core_a2;
    logic [SB-1:0] core_b2;
    logic [SP-1:0] core_p2;
    logic [15:0]   op_count2;

    muldiv_seq #(.SIZE_A(SA), .SIZE_B(SB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .core_en(core_en), .core_select(core_select), .core_a(core_a), .core_b(core_b),
        .core_p(core_p), .core_valid(core_valid), .core_busy(core_busy), .op_count(op_count)
    );

    muldiv_seq #(.SIZE_A(SA), .SIZE_B(SB), .TIMEOUT(20)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .core_en(core_en2), .core_select(core_select2), .core_a(core_a2), .core_b(core_b2),
        .core_p(core_p2), .core_valid(core_valid2), .core_busy(core_busy2), .op_count(op_count2)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [SP-1:0] act, input logic [SP-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural core: result appears cm_lat cycles after the start pulse.
    int            cm_lat = 4;
    logic [7:0]    cm_cnt;
    logic          cm_busy;
    logic          ext_busy = 1'b0;
    logic [SP-1:0] cm_res;
    assign core_busy = cm_busy | ext_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cm_cnt     <= '0;
            cm_busy    <= 1'b0;
            core_valid <= 1'b0;
            core_p     <= '0;
            cm_res     <= '0;
        end else begin
            core_valid <= 1'b0;
            if (cm_cnt != 0) begin
                cm_cnt <= cm_cnt - 8'd1;
                if (cm_cnt == 8'd1) begin
                    core_valid <= 1'b1;
                    cm_busy    <= 1'b0;
                    core_p     <= cm_res;
                end
            end else if (core_en) begin
                cm_busy <= 1'b1;
                cm_cnt  <= 8'(cm_lat);
                cm_res  <= core_select ? SP'(core_a / SA'(core_b)) : SP'(core_a) * SP'(core_b);
            end
        end
    end

    int en_count = 0;
    always @(posedge clk) if (core_en) en_count <= en_count + 1;

    typedef struct {
        logic [SP-1:0] data;
        logic [3:0]    tag;
        logic          err;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", bus.rsp_data, e.data);
                check("rsp_tag", SP'(bus.rsp_tag), SP'(e.tag));
                check("rsp_err", SP'(bus.rsp_err), SP'(e.err));
            end
        end
    end

    task automatic send(input logic op, input logic [SA-1:0] a, input logic [SB-1:0] b,
                        input logic [3:0] tg, input logic [SP-1:0] exp, input logic err);
        int t = 0;
        sb.push_back('{data: exp, tag: tg, err: err});
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tg;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_ready", SP'(bus.req_ready), SP'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_sb_empty();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("rsp_arrived", SP'(sb.size()), SP'(0));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic          op;
        logic [SA-1:0] a;
        logic [SB-1:0] b;
        logic [3:0]    tag;
        logic [SP-1:0] exp;
        logic          err;
    } vec_t;
    vec_t vecs[8];

    int exp_oc = 0;

    initial begin
        int en0;
        int t;
        logic [SP-1:0] all_ones;
        all_ones = '1;

        vecs[0] = '{1'b0, SA'(3), SB'(5), 4'd1, SP'(15), 1'b0};
        vecs[1] = '{1'b0, {SA{1'b1}}, SB'(2), 4'd2, {63'd0, {128{1'b1}}, 1'b0}, 1'b0};
        vecs[2] = '{1'b1, SA'(1000), SB'(7), 4'd3, SP'(142), 1'b0};
        vecs[3] = '{1'b1, SA'(7), SB'(1000), 4'd4, SP'(0), 1'b0};
        vecs[4] = '{1'b1, SA'(100), SB'(0), 4'd7, all_ones, 1'b1};
        vecs[5] = '{1'b0, SA'(0), SB'(9), 4'd15, SP'(0), 1'b0};
        vecs[6] = '{1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, SB'(1), 4'd6,
                    SP'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210), 1'b0};
        vecs[7] = '{1'b0, {SA{1'b1}}, {SB{1'b1}}, 4'd8,
                    192'hFFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF_0000000000000001, 1'b0};

        bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_a = '0; bus.req_b = '0;
        bus.req_tag = '0; bus.rsp_ready = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_op = 1'b0; bus2.req_a = '0; bus2.req_b = '0;
        bus2.req_tag = '0; bus2.rsp_ready = 1'b0;
        core_busy2 = 1'b0; core_valid2 = 1'b0; core_p2 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", SP'(bus.rsp_valid), SP'(0));
        check("rst_core_en", SP'(core_en), SP'(0));
        check("rst_op_count", SP'(op_count), SP'(0));
        check("rst_rsp_data", bus.rsp_data, SP'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", SP'(bus.req_ready), SP'(1));

        // Multiply 3*5 with a 64-cycle core, response held back for 10 cycles
        cm_lat = 64;
        en0 = en_count;
        send(1'b0, SA'(3), SB'(5), 4'd2, SP'(15), 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!core_valid && t < 200);
        check("mul_core_valid_seen", SP'(core_valid), SP'(1));
        check("mul_pre_latency", SP'(bus.rsp_valid), SP'(0));
        @(negedge clk);
        check("mul_latency", SP'(bus.rsp_valid), SP'(1));
        check("mul_en_pulses", SP'(en_count - en0), SP'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_data", bus.rsp_data, SP'(15));
            check("hold_tag", SP'(bus.rsp_tag), SP'(2));
            check("hold_err", SP'(bus.rsp_err), SP'(0));
            check("hold_req_ready", SP'(bus.req_ready), SP'(0));
            check("hold_rsp_valid", SP'(bus.rsp_valid), SP'(1));
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_sb_empty();
        exp_oc++;
        check("mul_op_count", SP'(op_count), SP'(exp_oc));

        // Vector table, consumer always ready
        for (int i = 0; i < 8; i++) begin
            cm_lat = int'($urandom_range(1, 6));
            en0 = en_count;
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].err);
            wait_sb_empty();
            exp_oc++;
            check("vec_en_pulses", SP'(en_count - en0), SP'(vecs[i].err ? 0 : 1));
            check("vec_op_count", SP'(op_count), SP'(exp_oc));
        end

        // Divide by zero: response visible one cycle after accept, core untouched
        bus.rsp_ready = 1'b0;
        en0 = en_count;
        send(1'b1, SA'(100), SB'(0), 4'd7, all_ones, 1'b1);
        check("dz_latency", SP'(bus.rsp_valid), SP'(1));
        check("dz_data", bus.rsp_data, all_ones);
        repeat (3) @(posedge clk);
        #1;
        check("dz_no_core_en", SP'(en_count - en0), SP'(0));
        bus.rsp_ready = 1'b1;
        wait_sb_empty();
        exp_oc++;

        // Busy core at accept: start pulse withheld until busy falls
        ext_busy = 1'b1;
        cm_lat = 3;
        en0 = en_count;
        send(1'b0, SA'(6), SB'(7), 4'd5, SP'(42), 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy_core_en_low", SP'(core_en), SP'(0));
        end
        @(posedge clk); #1;
        ext_busy = 1'b0;
        wait_sb_empty();
        exp_oc++;
        check("busy_en_pulses", SP'(en_count - en0), SP'(1));
        check("busy_op_count", SP'(op_count), SP'(exp_oc));

        // Reset during WAIT discards the pending response
        cm_lat = 64;
        send(1'b0, SA'(2), SB'(2), 4'd9, SP'(4), 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        check("arst_rsp_valid", SP'(bus.rsp_valid), SP'(0));
        check("arst_core_en", SP'(core_en), SP'(0));
        check("arst_op_count", SP'(op_count), SP'(0));
        check("arst_rsp_data", bus.rsp_data, SP'(0));
        check("arst_core_a", SP'(core_a), SP'(0));
        sb.delete();
        exp_oc = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arst_req_ready", SP'(bus.req_ready), SP'(1));
        cm_lat = 4;
        send(1'b0, SA'(11), SB'(13), 4'd10, SP'(143), 1'b0);
        wait_sb_empty();
        exp_oc++;
        check("arst_op_count_after", SP'(op_count), SP'(exp_oc));

        // Timeout instance: core never answers
        bus2.req_op = 1'b0; bus2.req_a = SA'(1); bus2.req_b = SB'(1); bus2.req_tag = 4'd12;
        bus2.req_valid = 1'b1;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        t = 0;
        while (!core_en2 && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        check("to_core_en", SP'(core_en2), SP'(1));
        t = 0;
        while (!bus2.rsp_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("to_latency", SP'(t), SP'(21));
        check("to_err", SP'(bus2.rsp_err), SP'(1));
        check("to_data", bus2.rsp_data, all_ones);
        check("to_tag", SP'(bus2.rsp_tag), SP'(12));
        bus2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus2.rsp_ready = 1'b0;
        check("to_op_count", SP'(op_count2), SP'(1));
        core_p2 = SP'(5);
        core_valid2 = 1'b1;
        @(posedge clk); #1;
        core_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("late_valid_ignored", SP'(bus2.rsp_valid), SP'(0));
        check("late_req_ready", SP'(bus2.req_ready), SP'(1));
        check("late_op_count", SP'(op_count2), SP'(1));

        // Result on the timeout cycle beats the abort
        bus2.req_tag = 4'd13;
        bus2.req_valid = 1'b1;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        t = 0;
        while (!core_en2 && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (20) @(posedge clk);
        #1;
        check("prio_not_yet", SP'(bus2.rsp_valid), SP'(0));
        core_p2 = SP'(16'h1234);
        core_valid2 = 1'b1;
        @(posedge clk); #1;
        core_valid2 = 1'b0;
        check("prio_rsp_valid", SP'(bus2.rsp_valid), SP'(1));
        check("prio_err", SP'(bus2.rsp_err), SP'(0));
        check("prio_data", bus2.rsp_data, SP'(16'h1234));
        check("prio_tag", SP'(bus2.rsp_tag), SP'(13));
        bus2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus2.rsp_ready = 1'b0;
        check("prio_op_count", SP'(op_count2), SP'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SIZE_A, default 128, dividend/multiplicand width.
REQ-002 SIZE_B, default 64, divisor/multiplier width.
REQ-003 TIMEOUT, default 1023, maximum WAIT cycles before abort (10-bit range).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  upstream request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_op  in  1  operation select: 0 = multiply, 1 = divide.
REQ-009 req_a  in  SIZE_A  first operand.
REQ-010 req_b  in  SIZE_B  second operand.
REQ-011 req_tag  in  4  caller ID, returned with the result.
REQ-012 core_en  out  1  one-cycle start pulse to the arithmetic core.
REQ-013 core_select  out  1  operation to the core, equal to the latched req_op.
REQ-014 core_a / core_b  out  SIZE_A / SIZE_B  latched operands to the core.
REQ-015 core_p  in  SIZE_A+SIZE_B  core result.
REQ-016 core_valid  in  1  core result valid, one-cycle pulse.
REQ-017 core_busy  in  1  core computing.
REQ-018 rsp_valid  out  1  result available downstream.
REQ-019 rsp_ready  in  1  downstream accepts the result.
REQ-020 rsp_data  out  SIZE_A+SIZE_B  result word.
REQ-021 rsp_tag  out  4  tag of the request that produced this result.
REQ-022 rsp_err  out  1  1 = divide-by-zero or timeout; rsp_data is then all ones.
REQ-023 op_count  out  16  count of completed responses, saturating.

Function
REQ-024 The FSM SHALL have four states: IDLE, ISSUE, WAIT, HOLD.
REQ-025 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-026 On accept, the block SHALL latch op, a, b and tag into internal registers, which then drive core_select, core_a and core_b.
REQ-027 On accept with req_op=1 and req_b=0:
 - go IDLE->HOLD directly, with rsp_data = all ones and rsp_err = 1;
 - the core SHALL NOT be started.
REQ-028 On any other accept, the FSM SHALL go IDLE->ISSUE.
REQ-029 In ISSUE, core_en SHALL be 1 for exactly the first cycle in which core_busy=0 and core_valid=0; the FSM SHALL go to WAIT on the following edge.
REQ-030 In every other cycle, core_en SHALL be 0.
REQ-031 In WAIT, a 10-bit counter SHALL increment each cycle, starting from 0.
REQ-032 If core_valid=1 in WAIT, the block SHALL capture rsp_data = core_p, set rsp_err = 0 and go to HOLD on that edge.
REQ-033 If the WAIT counter reaches TIMEOUT with no core_valid, the block SHALL go to HOLD with rsp_data = all ones and rsp_err = 1.
REQ-034 If core_valid and the timeout occur in the same cycle, core_valid SHALL take priority.
REQ-035 In HOLD, rsp_valid SHALL be 1, and rsp_data, rsp_tag and rsp_err SHALL stay stable until rsp_ready=1.
REQ-036 On HOLD with rsp_ready=1, the block SHALL go to IDLE and increment op_count, saturating at 0xFFFF.
REQ-037 core_valid pulses arriving outside WAIT SHALL be ignored.
REQ-038 Latency, non-error case: rsp_valid SHALL rise on the edge that samples core_valid=1, i.e. one cycle after the core pulse.
REQ-039 Minimum latency accept -> rsp_valid for divide-by-zero SHALL be 1 cycle.
REQ-040 Throughput SHALL be one request in flight; no new accept until HOLD is left.
REQ-041 All outputs SHALL be registered, except req_ready and rsp_valid, which are decoded from state.

Reset
REQ-042 On reset_n low, the block SHALL asynchronously force:
 - state = IDLE and the WAIT counter = 0;
 - all latched operands, tag, rsp_data, rsp_err and op_count = 0;
 - core_en = 0.
REQ-043 Reset asserted in ISSUE, WAIT or HOLD SHALL abort the operation; the pending response SHALL be discarded and not counted.
REQ-044 After reset_n rises, req_ready SHALL be 1 from the first clock edge.

Verification
REQ-045 Multiply a=3, b=5, tag=2; core model returns core_p=15 after 64 cycles -> one core_en pulse; rsp_valid with rsp_data=15, rsp_tag=2, rsp_err=0; op_count=1.
REQ-046 Divide a=100, b=0, tag=7 -> no core_en; rsp_valid on the next cycle with rsp_data all ones, rsp_err=1, rsp_tag=7.
REQ-047 Core model never asserts core_valid, TIMEOUT=20 -> rsp_valid 21 cycles after entering WAIT, rsp_err=1; a late core_valid afterwards is ignored.
REQ-048 rsp_ready held 0 for 10 cycles in HOLD -> rsp_data/tag/err stable, req_ready=0 throughout; accept occurs only after rsp_ready=1.
REQ-049 core_busy=1 when the request is accepted -> core_en is withheld until core_busy falls, then pulses exactly once.
REQ-050 reset_n pulsed low during WAIT -> all outputs 0 immediately, op_count unchanged at 0, the next request completes normally.
